// File: rtl/rotate_left_pipe_pkg.sv
// Shared types and helpers for the three-stage base-3 rotator.
// SHIFTER_LSL_EN adds a per-item mode bit selecting zero-fill shift.
package shifter_pkg;

   localparam int SHIFT_W    = 16;
   localparam int NUM_STAGES = 3;
   localparam int AMT_BITS   = 4;

   // Base-3 digit; the code 2'd3 never occurs for legal amounts.
   typedef logic [1:0] trit_t;
   typedef trit_t [NUM_STAGES-1:0] trits_t;

   typedef struct packed {
      logic [SHIFT_W-1:0] data;
      trits_t             trits;
`ifdef SHIFTER_LSL_EN
      logic               mode;
`endif
   } stage_t;

   function automatic trits_t to_trits(
      input logic [AMT_BITS-1:0] amt
   );
      trits_t              t;
      logic [AMT_BITS-1:0] q;
      t[0] = trit_t'(amt % 4'd3);
      q    = amt / 4'd3;
      t[1] = trit_t'(q % 4'd3);
      t[2] = trit_t'(q / 4'd3);
      return t;
   endfunction

   function automatic logic [SHIFT_W-1:0] rol_f(
      input logic [SHIFT_W-1:0] x,
      input int                 n
   );
      logic [2*SHIFT_W-1:0] w;
      w = {x, x} << (n % SHIFT_W);
      return w[2*SHIFT_W-1:SHIFT_W];
   endfunction

   function automatic logic [SHIFT_W-1:0] lsl_f(
      input logic [SHIFT_W-1:0] x,
      input int                 n
   );
      logic [SHIFT_W-1:0] r;
      r = '0;
      if (n < SHIFT_W)
         r = x << n;
      return r;
   endfunction

endpackage

// File: rtl/rotate_left_pipe_if.sv
// Valid/ready bundle carrying operands in and results out.
// Mode is always present; it only matters when SHIFTER_LSL_EN is set.
interface rotate_left_pipe_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
);

   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] In;
   logic [AMT_W-1:0] Amount;
   logic             Mode;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] Out;

   modport master (
      output InValid,
      output In,
      output Amount,
      output Mode,
      output OutReady,
      input  InReady,
      input  OutValid,
      input  Out
   );

   modport slave (
      input  InValid,
      input  In,
      input  Amount,
      input  Mode,
      input  OutReady,
      output InReady,
      output OutValid,
      output Out
   );

endinterface

// File: rtl/rotate_left_pipe_rol_stage.sv
// One pipeline stage: rotate by 0, WEIGHT or 2*WEIGHT, then register.
// SHIFTER_LSL_EN lets the carried mode bit select zero-fill instead.
module rol_stage
   import shifter_pkg::*;
#(
   parameter int WEIGHT = 1
) (
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_valid,
   output logic   o_ready,
   input  stage_t i_bus,
   output logic   o_valid,
   output stage_t o_bus,
   input  logic   i_ready
);

   localparam int IDX = (WEIGHT == 9) ? 2 :
                        (WEIGHT == 3) ? 1 : 0;

   logic               r_valid;
   stage_t             r_bus;
   trit_t              w_dig;
   logic [SHIFT_W-1:0] w_rot1;
   logic [SHIFT_W-1:0] w_rot2;
   stage_t             w_nxt;
   logic               w_load;

   assign w_dig = i_bus.trits[IDX];

`ifdef SHIFTER_LSL_EN
   assign w_rot1 = i_bus.mode ?
                   lsl_f(i_bus.data, WEIGHT) :
                   rol_f(i_bus.data, WEIGHT);
   assign w_rot2 = i_bus.mode ?
                   lsl_f(i_bus.data, 2 * WEIGHT) :
                   rol_f(i_bus.data, 2 * WEIGHT);
`else
   assign w_rot1 = rol_f(i_bus.data, WEIGHT);
   assign w_rot2 = rol_f(i_bus.data, 2 * WEIGHT);
`endif

   always_comb begin
      w_nxt = i_bus;
      case (w_dig)
         2'd1:    w_nxt.data = w_rot1;
         2'd2:    w_nxt.data = w_rot2;
         default: w_nxt.data = i_bus.data;
      endcase
   end

   // Accept when empty or when our own contents leave this cycle.
   assign o_ready = !i_rst && (!r_valid || i_ready);
   assign w_load  = i_valid && o_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_bus   <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_bus   <= w_nxt;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_bus   = r_bus;

`ifndef SYNTHESIS
   always @(posedge i_clk) begin
      if (!i_rst && i_valid)
         assert (w_dig != 2'd3);
   end
`endif

endmodule

// File: rtl/rotate_left_pipe.sv
// 16-bit left rotator split into base-3 digit stages (weights 1, 3, 9).
// Define SHIFTER_LSL_EN to make Mode=1 perform a logical shift left.
module rotate_left_pipe
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input logic               Clk,
   input logic               Rst,
   rotate_left_pipe_if.slave bus
);

   logic [WIDTH-1:0] w_in;
   logic [AMT_W-1:0] w_amt;
   stage_t           w_bus [NUM_STAGES+1];
   logic             w_vld [NUM_STAGES+1];
   logic             w_rdy [NUM_STAGES+1];
   logic             w_unused;

   assign w_in  = bus.In;
   assign w_amt = bus.Amount;

   assign w_bus[0].data  = w_in;
   assign w_bus[0].trits = to_trits(w_amt);
`ifdef SHIFTER_LSL_EN
   assign w_bus[0].mode  = bus.Mode;
`endif

   assign w_vld[0]          = bus.InValid;
   assign bus.InReady       = w_rdy[0];
   assign w_rdy[NUM_STAGES] = bus.OutReady;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      rol_stage #(
         .WEIGHT (3 ** k)
      ) u_stage (
         .i_clk   (Clk),
         .i_rst   (Rst),
         .i_valid (w_vld[k]),
         .o_ready (w_rdy[k]),
         .i_bus   (w_bus[k]),
         .o_valid (w_vld[k+1]),
         .o_bus   (w_bus[k+1]),
         .i_ready (w_rdy[k+1])
      );
   end

   assign bus.OutValid = w_vld[NUM_STAGES];
   assign bus.Out      = w_bus[NUM_STAGES].data;

   // Digits and mode are spent once the last stage has used them.
`ifdef SHIFTER_LSL_EN
   assign w_unused = ^w_bus[NUM_STAGES];
`else
   assign w_unused = ^{w_bus[NUM_STAGES], bus.Mode};
`endif

endmodule
